// File: rtl/wisc_pkg.sv
// Shared definitions for the decode-stage register scoreboard.
//   NUM_REGS  number of architectural registers (matches register_file depth)
//   REG_W     register id width
//   reg_id_t  register id type (SrcReg1/SrcReg2/DstReg)
//   reg_vec_t one bit per architectural register
//   decodeId  register id -> one-hot register vector
package wisc_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = $clog2(NUM_REGS);

  typedef logic [REG_W-1:0]    reg_id_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic reg_vec_t decodeId(input reg_id_t id);
    reg_vec_t oneHot;
    oneHot     = '0;
    oneHot[id] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between decode and the register scoreboard.
//   master : decode side, presents instructions and writebacks, sees the gate
//   slave  : scoreboard side
// Signals:
//   iss_valid, iss_src1, iss_src2, iss_use1, iss_use2, iss_dst, iss_wr
//                    instruction presented for issue
//   iss_ready        instruction may issue this cycle (0 = stall)
//   wb_valid, wb_reg writeback landing in register_file this cycle
//   busy_vec         bit i = register i has at least one pending write
//   sb_err           sticky error flag
interface reg_scoreboard_if;
  import wisc_pkg::*;

  logic     iss_valid;
  logic     iss_ready;
  reg_id_t  iss_src1;
  reg_id_t  iss_src2;
  logic     iss_use1;
  logic     iss_use2;
  reg_id_t  iss_dst;
  logic     iss_wr;
  logic     wb_valid;
  reg_id_t  wb_reg;
  reg_vec_t busy_vec;
  logic     sb_err;

  modport master (
    output iss_valid, iss_src1, iss_src2, iss_use1, iss_use2, iss_dst, iss_wr,
    output wb_valid, wb_reg,
    input  iss_ready, busy_vec, sb_err
  );

  modport slave (
    input  iss_valid, iss_src1, iss_src2, iss_use1, iss_use2, iss_dst, iss_wr,
    input  wb_valid, wb_reg,
    output iss_ready, busy_vec, sb_err
  );

endinterface

// File: rtl/sb_entry.sv
// Pending-write counter for one architectural register.
//   clk   clock, state on rising edge
//   rst   synchronous active-high reset, clears the counter
//   inc   a write to this register issued this cycle
//   dec   a write to this register retired this cycle
//   busy  at least one write pending (from the registered count)
//   full  count at its maximum, 2**CNT_W-1
//   err   this cycle's event is illegal: retire with nothing pending, or
//         issue while full; the count holds in both cases
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  assign busy = (cnt != '0);
  assign full = (cnt == CNT_MAX);

  // A simultaneous issue and retire cancel out, so neither can be illegal.
  assign err = (dec & ~inc & ~busy) | (inc & ~dec & full);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc & ~dec & ~full) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & busy) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage issue gate in front of the register_file read ports.
// register_file has no write->read forwarding, so an instruction may only
// read a source once every write pending on it has landed. Each register has
// a small pending-write counter; the gate stalls on RAW hazards and when a
// destination counter is already saturated.
// Parameters:
//   CNT_W    pending-write counter width, up to 2**CNT_W-1 writes in flight
//   ZERO_R0  1 = register 0 is never tracked (never busy, never errors)
// Ports:
//   clk  clock, all state on rising edge
//   rst  synchronous active-high reset, discards all pending state
//   sb   issue/writeback/status bundle (slave side)
module reg_scoreboard
  import wisc_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  // Bit 0 cleared when R0 is hardwired, so R0 events never reach its counter.
  localparam reg_vec_t TRACK_MASK = ~reg_vec_t'(ZERO_R0);

  reg_vec_t busyVec;
  reg_vec_t fullVec;
  reg_vec_t errVec;
  reg_vec_t incVec;
  reg_vec_t decVec;
  logic     issReady;
  logic     issFire;
  logic     sbErr;

  // Ready looks only at registered counter state: a writeback landing this
  // cycle does not unblock its readers until the next cycle.
  assign issReady = ~(sb.iss_use1 & busyVec[sb.iss_src1])
                  & ~(sb.iss_use2 & busyVec[sb.iss_src2])
                  & ~(sb.iss_wr   & fullVec[sb.iss_dst]);

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    issFire = sb.iss_valid & issReady;
    incVec  = '0;
    decVec  = '0;
    if (issFire & sb.iss_wr) begin
      incVec = decodeId(sb.iss_dst) & TRACK_MASK;
    end
    if (sb.wb_valid) begin
      decVec = decodeId(sb.wb_reg) & TRACK_MASK;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gen_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .inc  (incVec[i]),
      .dec  (decVec[i]),
      .busy (busyVec[i]),
      .full (fullVec[i]),
      .err  (errVec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbErr <= 1'b0;
    end else if (|errVec) begin
      sbErr <= 1'b1;
    end
  end

  assign sb.iss_ready = issReady;
  // busyVec decodes the counter flops directly, so it moves one cycle after
  // the issue/retire that changed the count.
  assign sb.busy_vec  = busyVec;
  assign sb.sb_err    = sbErr;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written
// reset and R0 sequences, and randomized traffic against a counting model.
module tb_reg_scoreboard;
  import wisc_pkg::*;

  localparam int CNT_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if bus ();
  reg_scoreboard_if bus0 ();

  reg_scoreboard #(.CNT_W(CNT_W), .ZERO_R0(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  reg_scoreboard #(.CNT_W(CNT_W), .ZERO_R0(1'b1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .sb  (bus0)
  );

  typedef struct {
    logic        valid;
    reg_id_t     src1;
    logic        use1;
    reg_id_t     src2;
    logic        use2;
    reg_id_t     dst;
    logic        wr;
    logic        wbValid;
    reg_id_t     wbReg;
    logic        expReady;
    logic [15:0] expBusy;
    logic        expErr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int mCnt[NUM_REGS];
  bit mErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input int src1, input logic use1,
                              input int src2, input logic use2, input int dst,
                              input logic wr, input logic wbValid, input int wbReg,
                              input logic expReady, input logic [15:0] expBusy,
                              input logic expErr);
    vec_t v;
    v.valid = valid;   v.src1 = reg_id_t'(src1); v.use1 = use1;
    v.src2 = reg_id_t'(src2); v.use2 = use2;     v.dst = reg_id_t'(dst);
    v.wr = wr;         v.wbValid = wbValid;      v.wbReg = reg_id_t'(wbReg);
    v.expReady = expReady; v.expBusy = expBusy;  v.expErr = expErr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.iss_valid = v.valid;
    bus.iss_src1  = v.src1;
    bus.iss_use1  = v.use1;
    bus.iss_src2  = v.src2;
    bus.iss_use2  = v.use2;
    bus.iss_dst   = v.dst;
    bus.iss_wr    = v.wr;
    bus.wb_valid  = v.wbValid;
    bus.wb_reg    = v.wbReg;
  endtask

  task automatic idle0();
    bus0.iss_valid = 1'b0; bus0.iss_src1 = '0; bus0.iss_use1 = 1'b0;
    bus0.iss_src2  = '0;   bus0.iss_use2 = 1'b0; bus0.iss_dst = '0;
    bus0.iss_wr    = 1'b0; bus0.wb_valid = 1'b0; bus0.wb_reg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    idle0();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    foreach (mCnt[i]) mCnt[i] = 0;
    mErr = 1'b0;
  endtask

  // Reference model: per-register count of writes in flight.
  function automatic logic mReady(input vec_t v);
    return !(v.use1 && mCnt[v.src1] > 0) && !(v.use2 && mCnt[v.src2] > 0)
        && !(v.wr && mCnt[v.dst] == MAX);
  endfunction

  function automatic logic [15:0] mBusy();
    logic [15:0] b;
    for (int i = 0; i < NUM_REGS; i++) b[i] = (mCnt[i] != 0);
    return b;
  endfunction

  task automatic mStep(input vec_t v);
    int d[NUM_REGS];
    bit fire;
    fire = v.valid && mReady(v);
    foreach (d[i]) d[i] = 0;
    if (fire && v.wr) d[v.dst] += 1;
    if (v.wbValid)    d[v.wbReg] -= 1;
    for (int i = 0; i < NUM_REGS; i++) begin
      int n;
      n = mCnt[i] + d[i];
      if (n < 0) begin
        n = 0;
        mErr = 1'b1;
      end
      mCnt[i] = n;
    end
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b0;
    idle0();
    doReset();

    // Directed table: each row is driven for one cycle; expectations are the
    // outputs observed during that cycle, before the next rising edge.
    //            vld s1 u1 s2 u2 dst wr wbv wbr  rdy busy      err
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  1, 16'h0000, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 16'h0008, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 3,  0, 16'h0008, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 5,  0, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  1, 16'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7,  1, 16'h00A0, 0));
    vecs.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 16'h00A0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9,  1, 16'h00A0, 0));
    vecs.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 16'h00A0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 16'h00A0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5,  1, 16'h00A0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5,  1, 16'h00A0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5,  1, 16'h00A0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7,  1, 16'h0080, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0,  1, 16'h0000, 1));
    vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 1));

    check("reset_busy", bus.busy_vec, 16'h0000);
    check("reset_err", bus.sb_err, 1'b0);

    foreach (vecs[k]) begin
      drive(vecs[k]);
      #1;
      check($sformatf("vec%0d_ready", k), bus.iss_ready, vecs[k].expReady);
      check($sformatf("vec%0d_busy", k), bus.busy_vec, vecs[k].expBusy);
      check($sformatf("vec%0d_err", k), bus.sb_err, vecs[k].expErr);
      tick();
    end

    // Reset mid-operation discards pending writes and the sticky error.
    drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0, 0));
    tick();
    drive(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 16'h0, 0));
    tick();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    #1;
    check("pre_rst_busy", bus.busy_vec, 16'h0006);
    check("pre_rst_err", bus.sb_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_busy", bus.busy_vec, 16'h0000);
    check("post_rst_err", bus.sb_err, 1'b0);
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    #1;
    check("post_rst_ready_r1", bus.iss_ready, 1'b1);
    tick();

    // Randomized traffic against the model; ids kept small to force hazards.
    doReset();
    for (int c = 0; c < 600; c++) begin
      vec_t v;
      int pend[$];
      if (c % 150 == 149) doReset();
      v.valid = 1'($urandom_range(0, 3) != 0);
      v.src1  = reg_id_t'($urandom_range(0, 5));
      v.use1  = 1'($urandom_range(0, 1));
      v.src2  = reg_id_t'($urandom_range(0, 5));
      v.use2  = 1'($urandom_range(0, 1));
      v.dst   = reg_id_t'($urandom_range(0, 5));
      v.wr    = 1'($urandom_range(0, 2) != 0);
      for (int i = 0; i < NUM_REGS; i++) if (mCnt[i] > 0) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 19) != 0) begin
        v.wbValid = 1'($urandom_range(0, 1));
        v.wbReg   = reg_id_t'(pend[$urandom_range(0, pend.size() - 1)]);
      end else begin
        v.wbValid = 1'($urandom_range(0, 7) == 0);
        v.wbReg   = reg_id_t'($urandom_range(0, NUM_REGS - 1));
      end
      drive(v);
      #1;
      check($sformatf("rnd%0d_ready", c), bus.iss_ready, mReady(v));
      check($sformatf("rnd%0d_busy", c), bus.busy_vec, mBusy());
      check($sformatf("rnd%0d_err", c), bus.sb_err, mErr);
      tick();
      mStep(v);
    end

    // ZERO_R0 instance: R0 never counted, never blocks, never errors.
    doReset();
    for (int k = 0; k < MAX + 1; k++) begin
      bus0.iss_valid = 1'b1;
      bus0.iss_wr    = 1'b1;
      bus0.iss_dst   = '0;
      #1;
      check($sformatf("r0_issue%0d_ready", k), bus0.iss_ready, 1'b1);
      tick();
    end
    idle0();
    bus0.wb_valid = 1'b1;
    bus0.wb_reg   = '0;
    #1;
    check("r0_busy", bus0.busy_vec, 16'h0000);
    tick();
    idle0();
    bus0.iss_valid = 1'b1;
    bus0.iss_wr    = 1'b1;
    bus0.iss_dst   = reg_id_t'(4);
    bus0.iss_use1  = 1'b1;
    bus0.iss_src1  = '0;
    #1;
    check("r0_wb_err", bus0.sb_err, 1'b0);
    check("r0_src_ready", bus0.iss_ready, 1'b1);
    tick();
    idle0();
    #1;
    check("r0_r4_busy", bus0.busy_vec, 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
